simon_game_ctrl: RTL and testbench
==================================

// Module: simon_game_ctrl
// PURPOSE
//  Parametrised successor to the Simon controller FSM: sequences INPUT -> PLAYBACK -> REPEAT -> DONE across
//  NUM_PLAYERS players with rotating turns, timed playback (LED on/off pacing), repeat-phase timeout,
//  bounded sequence depth, and restart without reset. Drives datapath counters/RAM write; consumes compare flags.
// PARAMETERS
//  NUM_PLAYERS   2     players in rotation (>=2); PW = max(1,$clog2(NUM_PLAYERS))
//  SEQ_DEPTH     16    max patterns stored; reaching it ends game (no loser)
//  ON_CYC_SLOW   4     playback LED-on cycles, lvl=0 (>=1)
//  ON_CYC_FAST   2     playback LED-on cycles, lvl=1 (>=1)
//  OFF_CYC       1     playback gap cycles, LED off (>=1)
//  TIMEOUT_CYC   64    REPEAT cycles allowed between entries before forfeit (>=1)
// PORTS
//  clk           in   1   system clock
//  rst           in   1   asynchronous, active-low reset
//  lvl           in   1   speed: 0 slow, 1 fast; sampled when each PB_ON is entered
//  restart       in   1   in DONE: clear and begin new game
//  legal         in   1   INPUT: entered pattern legal (single-cycle strobe)
//  entry         in   1   REPEAT: player press valid this cycle
//  correct       in   1   REPEAT: press matches stored pattern (qualified by entry)
//  more          in   1   playback index has further stored entries
//  wr            out  1   write pattern RAM
//  seq_ctr_inc   out  1   advance sequence-length counter
//  seq_ctr_clr   out  1   clear sequence-length counter
//  pbrd_ctr_inc  out  1   advance playback/read counter
//  pbrd_ctr_clr  out  1   clear playback/read counter
//  led           out  1   pattern display enable
//  mode_leds     out  3   001 INPUT, 010 PB_ON/PB_OFF, 100 REPEAT, 111 DONE
//  cur_player    out  PW  active player
//  game_over     out  1   high in DONE
//  has_loser     out  1   DONE by error/timeout (0 = depth reached)
//  loser         out  PW  losing player, valid when has_loser
// BEHAVIOUR
//  Reset (rst=0, async): state=INPUT, cur_player=0, seq_len=0, timer=0, loser=0, has_loser=0; all strobes 0,
//   mode_leds=001. Strobe outputs are Moore/Mealy combinational from state+inputs; state/regs update on posedge clk.
//  INPUT: legal -> wr=1, seq_ctr_inc=1, pbrd_ctr_clr=1, seq_len++; if new seq_len==SEQ_DEPTH -> DONE (has_loser=0)
//   else -> PB_ON, timer loaded with ON_CYC_(lvl). legal=0 -> stay, no strobes.
//  PB_ON: led=1; timer expiry -> PB_OFF, load OFF_CYC. PB_OFF: led=0; expiry: more -> pbrd_ctr_inc, PB_ON;
//   !more -> pbrd_ctr_clr, cur_player=(cur_player+1) mod NUM_PLAYERS, REPEAT, load TIMEOUT_CYC.
//   Expiry = counter reaches 1; an N-cycle load gives exactly N cycles in state.
//  REPEAT: entry&!correct -> DONE, has_loser=1, loser=cur_player. entry&correct&more -> pbrd_ctr_inc, reload
//   timeout, stay. entry&correct&!more -> INPUT (same player appends). No entry and timeout expiry -> DONE as loss.
//   entry on expiry cycle takes priority over timeout.
//  DONE: game_over=1, led=1; hold. restart -> seq_ctr_clr=1, pbrd_ctr_clr=1, cur_player=0, has_loser=0, INPUT.
//  Ignored: legal outside INPUT, entry/correct outside REPEAT, restart outside DONE, lvl mid-PB_ON.
//  Wrap: cur_player wraps NUM_PLAYERS-1 -> 0; seq_len never exceeds SEQ_DEPTH (saturating).
//  Reset asserted mid-game returns to reset values immediately regardless of state/timer.
//  Unreachable state encodings recover to INPUT on next clock.
// STRUCTURE
//  simon_pkg: state encoding (INPUT, PB_ON, PB_OFF, REPEAT, DONE), MODE_LEDS_* constants, clog2 helper.
//  Sub-module simon_timer: load/value/expire down-counter, width $clog2(max cycle param)+1; one instance
//   shared by playback pacing and repeat timeout.
//  Top: state register, seq_len and cur_player registers, output decode.
// TESTING
//  T1 reset mid PB_ON -> outputs at reset values same cycle, INPUT/001 after release, cur_player=0.
//  T2 lvl=0, legal pulse, more=0 -> wr/seq_ctr_inc 1 cycle, led high 4 cycles, low 1, then REPEAT cur_player=1.
//  T3 REPEAT, 3 correct entries with more=1,1,0 -> 2 pbrd_ctr_inc pulses, then INPUT, player unchanged.
//  T4 REPEAT, no entry 64 cycles -> DONE, has_loser=1, loser=cur_player; entry&!correct also -> DONE loss.
//  T5 SEQ_DEPTH=3, three rounds all correct -> 3rd legal -> DONE, has_loser=0; restart -> clr strobes, INPUT.
//  T6 NUM_PLAYERS=3 -> cur_player sequence 0,1,2,0 over rounds; lvl=1 -> led on exactly 2 cycles.

Source files
------------

// File: rtl/simon_pkg.sv
// rtl/simon_pkg.sv - shared state encoding, mode LED patterns and sizing helpers
package simon_pkg;

  typedef enum logic [2:0] {
    S_INPUT  = 3'd0,
    S_PB_ON  = 3'd1,
    S_PB_OFF = 3'd2,
    S_REPEAT = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  localparam logic [2:0] MODE_LEDS_INPUT  = 3'b001;
  localparam logic [2:0] MODE_LEDS_PB     = 3'b010;
  localparam logic [2:0] MODE_LEDS_REPEAT = 3'b100;
  localparam logic [2:0] MODE_LEDS_DONE   = 3'b111;

  // Width of a player index; a single bit even for the degenerate cases.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/simon_game_ctrl_if.sv
// rtl/simon_game_ctrl_if.sv - controller <-> datapath signal bundle
interface simon_game_ctrl_if #(
  parameter int NUM_PLAYERS = 2
);
  localparam int PW = simon_pkg::clog2_min1(NUM_PLAYERS);

  logic          lvl;
  logic          restart;
  logic          legal;
  logic          entry;
  logic          correct;
  logic          more;
  logic          wr;
  logic          seq_ctr_inc;
  logic          seq_ctr_clr;
  logic          pbrd_ctr_inc;
  logic          pbrd_ctr_clr;
  logic          led;
  logic [2:0]    mode_leds;
  logic [PW-1:0] cur_player;
  logic          game_over;
  logic          has_loser;
  logic [PW-1:0] loser;

  modport master (
    input  lvl, restart, legal, entry, correct, more,
    output wr, seq_ctr_inc, seq_ctr_clr, pbrd_ctr_inc, pbrd_ctr_clr,
           led, mode_leds, cur_player, game_over, has_loser, loser
  );

  modport slave (
    output lvl, restart, legal, entry, correct, more,
    input  wr, seq_ctr_inc, seq_ctr_clr, pbrd_ctr_inc, pbrd_ctr_clr,
           led, mode_leds, cur_player, game_over, has_loser, loser
  );

endinterface

// File: rtl/simon_timer.sv
// rtl/simon_timer.sv - loadable down-counter; expire while the count sits at 1
module simon_timer #(
  parameter int WIDTH = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] value,
  output logic             expire
);

  logic [WIDTH-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= value;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  // Loading N makes expire fire on the Nth cycle after the load edge.
  assign expire = (cnt == WIDTH'(1));

endmodule

// File: rtl/simon_game_ctrl.sv
// rtl/simon_game_ctrl.sv - multi-player Simon sequencing FSM
// INPUT -> PB_ON/PB_OFF playback -> REPEAT -> INPUT, ending in DONE on loss or full depth.
module simon_game_ctrl
  import simon_pkg::*;
#(
  parameter int NUM_PLAYERS = 2,
  parameter int SEQ_DEPTH   = 16,
  parameter int ON_CYC_SLOW = 4,
  parameter int ON_CYC_FAST = 2,
  parameter int OFF_CYC     = 1,
  parameter int TIMEOUT_CYC = 64
) (
  input logic               clk,
  input logic               rst,
  simon_game_ctrl_if.master bus
);

  localparam int PW   = clog2_min1(NUM_PLAYERS);
  localparam int SW   = $clog2(SEQ_DEPTH + 1);
  localparam int MAXC = max_int(max_int(ON_CYC_SLOW, ON_CYC_FAST), max_int(OFF_CYC, TIMEOUT_CYC));
  localparam int TW   = $clog2(MAXC) + 1;

  state_t          state, state_nxt;
  logic [PW-1:0]   cur_player, player_nxt, loser, loser_nxt;
  logic            has_loser, has_loser_nxt;
  logic [SW-1:0]   seq_len, seq_len_nxt;
  logic            tmr_load, tmr_expire;
  logic [TW-1:0]   tmr_val, on_val;
  logic            wr, seq_inc, seq_clr, pb_inc, pb_clr, led, game_over;
  logic [2:0]      mode_leds;

  simon_timer #(.WIDTH(TW)) u_timer (
    .clk    (clk),
    .rst    (rst),
    .load   (tmr_load),
    .value  (tmr_val),
    .expire (tmr_expire)
  );

  assign on_val = bus.lvl ? TW'(ON_CYC_FAST) : TW'(ON_CYC_SLOW);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_INPUT;
      cur_player <= '0;
      seq_len    <= '0;
      loser      <= '0;
      has_loser  <= 1'b0;
    end else begin
      state      <= state_nxt;
      cur_player <= player_nxt;
      seq_len    <= seq_len_nxt;
      loser      <= loser_nxt;
      has_loser  <= has_loser_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    player_nxt    = cur_player;
    loser_nxt     = loser;
    has_loser_nxt = has_loser;
    seq_len_nxt   = seq_len;
    tmr_load      = 1'b0;
    tmr_val       = '0;
    wr            = 1'b0;
    seq_inc       = 1'b0;
    seq_clr       = 1'b0;
    pb_inc        = 1'b0;
    pb_clr        = 1'b0;
    led           = 1'b0;
    case (state)
      S_INPUT: begin
        // Gated by rst so the strobes stay low while reset is held.
        if (bus.legal && rst) begin
          wr      = 1'b1;
          seq_inc = 1'b1;
          pb_clr  = 1'b1;
          if (seq_len != SW'(SEQ_DEPTH)) seq_len_nxt = seq_len + 1'b1;
          if (seq_len_nxt == SW'(SEQ_DEPTH)) begin
            state_nxt     = S_DONE;
            has_loser_nxt = 1'b0;
          end else begin
            state_nxt = S_PB_ON;
            tmr_load  = 1'b1;
            tmr_val   = on_val;
          end
        end
      end
      S_PB_ON: begin
        led = 1'b1;
        if (tmr_expire) begin
          state_nxt = S_PB_OFF;
          tmr_load  = 1'b1;
          tmr_val   = TW'(OFF_CYC);
        end
      end
      S_PB_OFF: begin
        if (tmr_expire) begin
          tmr_load = 1'b1;
          if (bus.more) begin
            pb_inc    = 1'b1;
            state_nxt = S_PB_ON;
            tmr_val   = on_val;
          end else begin
            pb_clr     = 1'b1;
            state_nxt  = S_REPEAT;
            tmr_val    = TW'(TIMEOUT_CYC);
            player_nxt = (cur_player == PW'(NUM_PLAYERS - 1)) ? '0 : cur_player + 1'b1;
          end
        end
      end
      S_REPEAT: begin
        // A press on the expiry cycle wins over the timeout.
        if (bus.entry) begin
          if (!bus.correct) begin
            state_nxt     = S_DONE;
            has_loser_nxt = 1'b1;
            loser_nxt     = cur_player;
          end else if (bus.more) begin
            pb_inc   = 1'b1;
            tmr_load = 1'b1;
            tmr_val  = TW'(TIMEOUT_CYC);
          end else begin
            state_nxt = S_INPUT;
          end
        end else if (tmr_expire) begin
          state_nxt     = S_DONE;
          has_loser_nxt = 1'b1;
          loser_nxt     = cur_player;
        end
      end
      S_DONE: begin
        led = 1'b1;
        if (bus.restart) begin
          seq_clr       = 1'b1;
          pb_clr        = 1'b1;
          player_nxt    = '0;
          has_loser_nxt = 1'b0;
          seq_len_nxt   = '0;
          state_nxt     = S_INPUT;
        end
      end
      default: state_nxt = S_INPUT;
    endcase
  end

  always_comb begin
    game_over = 1'b0;
    case (state)
      S_PB_ON, S_PB_OFF: mode_leds = MODE_LEDS_PB;
      S_REPEAT:          mode_leds = MODE_LEDS_REPEAT;
      S_DONE: begin
        mode_leds = MODE_LEDS_DONE;
        game_over = 1'b1;
      end
      default:           mode_leds = MODE_LEDS_INPUT;
    endcase
  end

  assign bus.wr           = wr;
  assign bus.seq_ctr_inc  = seq_inc;
  assign bus.seq_ctr_clr  = seq_clr;
  assign bus.pbrd_ctr_inc = pb_inc;
  assign bus.pbrd_ctr_clr = pb_clr;
  assign bus.led          = led;
  assign bus.mode_leds    = mode_leds;
  assign bus.cur_player   = cur_player;
  assign bus.game_over    = game_over;
  assign bus.has_loser    = has_loser;
  assign bus.loser        = loser;

endmodule

// File: tb/tb_simon_game_ctrl.sv
// tb/tb_simon_game_ctrl.sv - directed self-checking bench for simon_game_ctrl
module tb_simon_game_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   tests = 0;
  int   fails = 0;
  logic [31:0] led_q[$];

  always #5 clk = ~clk;

  simon_game_ctrl_if #(.NUM_PLAYERS(3)) bus ();

  simon_game_ctrl #(
    .NUM_PLAYERS (3),
    .SEQ_DEPTH   (4),
    .ON_CYC_SLOW (4),
    .ON_CYC_FAST (2),
    .OFF_CYC     (1),
    .TIMEOUT_CYC (64)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic ck(input string tag, input logic [31:0] obs, input logic [31:0] want);
    tests++;
    assert (obs === want) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
    end
  endtask

  task automatic sb_chk(input string tag, input logic [31:0] obs);
    logic [31:0] want;
    tests++;
    if (led_q.size() == 0) begin
      fails++;
      $error("FAIL %s: observed %0h expected <empty scoreboard>", tag, obs);
    end else begin
      want = led_q.pop_front();
      assert (obs === want) else begin
        fails++;
        $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
      end
    end
  endtask

  // One round from INPUT: legal pulse, pats playback slots, ends in REPEAT.
  task automatic round(input logic l, input int on_exp, input int exp_player, input int pats);
    int n;
    bus.lvl   = l;
    bus.legal = 1'b1;
    for (int p = 0; p < pats; p++) led_q.push_back(on_exp);
    #1;
    ck("wr", bus.wr, 1);
    ck("seq_inc", bus.seq_ctr_inc, 1);
    tick();
    bus.legal = 1'b0;
    for (int p = 0; p < pats; p++) begin
      n = 0;
      while (bus.led === 1'b1 && bus.mode_leds === 3'b010 && n < 40) begin
        n++;
        tick();
      end
      sb_chk("led_on_cycles", n);
      ck("pb_off_mode", {bus.led, bus.mode_leds}, 4'b0010);
      if (p < pats - 1) begin
        bus.more = 1'b1;
        #1;
        ck("pb_off_inc", bus.pbrd_ctr_inc, 1);
      end else begin
        bus.more = 1'b0;
        #1;
        ck("pb_off_clr", bus.pbrd_ctr_clr, 1);
      end
      tick();
    end
    ck("repeat_mode", bus.mode_leds, 3'b100);
    ck("rotated_player", bus.cur_player, exp_player);
  endtask

  task automatic repeat_ok();
    bus.entry   = 1'b1;
    bus.correct = 1'b1;
    bus.more    = 1'b0;
    tick();
    bus.entry = 1'b0;
    ck("back_to_input", bus.mode_leds, 3'b001);
  endtask

  task automatic do_restart();
    bus.restart = 1'b1;
    #1;
    ck("restart_clrs", {bus.seq_ctr_clr, bus.pbrd_ctr_clr}, 2'b11);
    tick();
    bus.restart = 1'b0;
    ck("restart_state", {bus.mode_leds, bus.has_loser, bus.game_over, 30'(bus.cur_player)}, {3'b001, 2'b00, 30'd0});
  endtask

  initial begin
    bus.lvl = 1'b0; bus.restart = 1'b0; bus.legal = 1'b0;
    bus.entry = 1'b0; bus.correct = 1'b0; bus.more = 1'b0;
    tick();
    tick();
    ck("rst_mode", bus.mode_leds, 3'b001);
    ck("rst_flags", {bus.game_over, bus.has_loser, bus.led, bus.wr}, 4'b0000);
    ck("rst_player", bus.cur_player, 0);
    rst = 1'b1;
    tick();

    // Slow playback, then three correct entries with more=1,1,0.
    round(1'b0, 4, 1, 1);
    bus.entry = 1'b1; bus.correct = 1'b1; bus.more = 1'b1;
    #1;
    ck("rep_inc_1", bus.pbrd_ctr_inc, 1);
    tick();
    ck("rep_stay", bus.mode_leds, 3'b100);
    ck("rep_inc_2", bus.pbrd_ctr_inc, 1);
    tick();
    bus.more = 1'b0;
    #1;
    ck("rep_last_no_inc", bus.pbrd_ctr_inc, 0);
    tick();
    bus.entry = 1'b0;
    ck("rep_to_input", bus.mode_leds, 3'b001);
    ck("same_player", bus.cur_player, 1);

    // Reset in the middle of PB_ON.
    bus.legal = 1'b1;
    tick();
    bus.legal = 1'b0;
    tick();
    ck("pb_on_led", bus.led, 1);
    rst = 1'b0;
    #1;
    ck("async_rst", {bus.mode_leds, bus.led, 28'(bus.cur_player)}, {3'b001, 1'b0, 28'd0});
    tick();
    rst = 1'b1;
    tick();
    ck("post_rst_mode", bus.mode_leds, 3'b001);

    // Rotation 1,2,0 with fast/slow/fast playback.
    round(1'b1, 2, 1, 1);
    repeat_ok();
    round(1'b0, 4, 2, 2);
    repeat_ok();
    round(1'b1, 2, 0, 1);
    // Press on the exact expiry cycle beats the timeout.
    repeat (63) tick();
    ck("expiry_cycle_mode", bus.mode_leds, 3'b100);
    bus.entry = 1'b1; bus.correct = 1'b1; bus.more = 1'b0;
    tick();
    bus.entry = 1'b0;
    ck("entry_beats_timeout", bus.mode_leds, 3'b001);

    // Fourth legal reaches depth: DONE with no loser.
    bus.legal = 1'b1;
    #1;
    ck("depth_wr", bus.wr, 1);
    tick();
    ck("depth_done", {bus.mode_leds, bus.has_loser, bus.game_over, bus.led}, 6'b111011);
    ck("ignored_legal", bus.wr, 0);
    tick();
    bus.legal = 1'b0;
    ck("done_hold", bus.mode_leds, 3'b111);
    do_restart();

    // Timeout forfeit.
    round(1'b0, 4, 1, 1);
    repeat (63) tick();
    ck("timeout_not_yet", bus.mode_leds, 3'b100);
    tick();
    ck("timeout_done", {bus.mode_leds, bus.has_loser, 28'(bus.loser)}, {3'b111, 1'b1, 28'd1});
    do_restart();

    // Wrong entry loss by player 2.
    round(1'b1, 2, 1, 1);
    repeat_ok();
    round(1'b1, 2, 2, 1);
    bus.entry = 1'b1; bus.correct = 1'b0;
    tick();
    bus.entry = 1'b0;
    ck("wrong_done", {bus.mode_leds, bus.has_loser, 28'(bus.loser)}, {3'b111, 1'b1, 28'd2});
    do_restart();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
